// File: rtl/ov7670_pixel_stream.sv
// OV7670 capture front end: samples the camera pins on PCLK, packs bytes into
// pixels, crops and decimates a window, tags each kept pixel with output
// coordinates and frame/line markers, and presents it on a valid/ready stage.
module ov7670_pixel_stream #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BPP      = 2,
  parameter int CROP_X0  = 0,
  parameter int CROP_Y0  = 0,
  parameter int CROP_W   = 640,
  parameter int CROP_H   = 480,
  parameter int DEC_X    = 1,
  parameter int DEC_Y    = 1,
  localparam int PW      = 8 * BPP
) (
  input  logic          c_PCLK,
  input  logic          rst,
  input  logic          capture_en,
  input  logic          c_VSYNC,
  input  logic          c_HREF,
  input  logic [7:0]    c_DOUT,
  output logic [PW-1:0] pix_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [9:0]    pix_x,
  output logic [8:0]    pix_y,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic          frame_done,
  output logic [15:0]   overflow_cnt,
  output logic [1:0]    err_status
);

  localparam int OUT_W = (CROP_W + DEC_X - 1) / DEC_X;

  // Comparison constants sized to the counters they are compared against
  localparam logic [10:0] X0    = 11'(CROP_X0);
  localparam logic [10:0] X_END = 11'(CROP_X0 + CROP_W);
  localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
  localparam logic [8:0]  Y0    = 9'(CROP_Y0);
  localparam logic [8:0]  Y_END = 9'(CROP_Y0 + CROP_H);
  localparam logic [8:0]  V_ACT = 9'(V_ACTIVE);
  localparam logic [3:0]  DXM1  = 4'(DEC_X - 1);
  localparam logic [3:0]  DYM1  = 4'(DEC_Y - 1);
  localparam logic [9:0]  OWM1  = 10'(OUT_W - 1);
  localparam logic        BPM1  = 1'(BPP - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, FRAME} state_t;

  state_t state, state_nxt;

  logic          vsync_p0, href_p0;
  logic [7:0]    acc_p0;
  logic          byte_ph;
  logic [10:0]   x_in;
  logic [8:0]    y_in;
  logic [3:0]    cph, lph;
  logic [9:0]    ox;
  logic [8:0]    oy;

  logic          vs_fall, vs_rise, href_fall;
  logic          in_frame, pix_done, col_in, y_win, row_keep, keep;
  logic [PW-1:0] pix_word;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [8:0] sat_inc9(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

  assign vs_fall   = vsync_p0 & ~c_VSYNC;
  assign vs_rise   = ~vsync_p0 & c_VSYNC;
  assign href_fall = href_p0 & ~c_HREF;

  assign in_frame  = (state == FRAME);
  assign pix_done  = in_frame && c_HREF && (byte_ph == BPM1);
  assign col_in    = (x_in >= X0) && (x_in < X_END);
  assign y_win     = (y_in >= Y0) && (y_in < Y_END);
  assign row_keep  = y_win && (lph == 4'd0);
  assign keep      = pix_done && col_in && row_keep && (cph == 4'd0);
  assign pix_word  = (BPP == 1) ? PW'(c_DOUT) : PW'({acc_p0, c_DOUT});

  // FSM state register
  always_ff @(posedge c_PCLK) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: frames start only on a VSYNC fall, end on a VSYNC rise
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture_en) state_nxt = WAIT_VS;
      WAIT_VS: begin
        if (vs_fall)          state_nxt = FRAME;
        else if (!capture_en) state_nxt = IDLE;
      end
      FRAME:   if (vs_rise) state_nxt = capture_en ? WAIT_VS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte holding register for the first byte of a two-byte pixel
  always_ff @(posedge c_PCLK) begin
    if (c_HREF) acc_p0 <= c_DOUT;
  end

  // ---- stage p0: pin copies, input position, crop/decimate phases, status
  always_ff @(posedge c_PCLK) begin
    if (rst) begin
      vsync_p0   <= 1'b0;
      href_p0    <= 1'b0;
      byte_ph    <= 1'b0;
      x_in       <= '0;
      y_in       <= '0;
      cph        <= '0;
      lph        <= '0;
      ox         <= '0;
      oy         <= '0;
      frame_done <= 1'b0;
      err_status <= '0;
    end else begin
      vsync_p0   <= c_VSYNC;
      href_p0    <= c_HREF;
      frame_done <= 1'b0;
      if (state == WAIT_VS && vs_fall) begin
        byte_ph <= 1'b0;
        x_in    <= '0;
        y_in    <= '0;
        cph     <= '0;
        lph     <= '0;
        ox      <= '0;
        oy      <= '0;
      end else if (in_frame) begin
        if (c_HREF) begin
          byte_ph <= (byte_ph == BPM1) ? 1'b0 : ~byte_ph;
          if (pix_done) begin
            x_in <= sat_inc11(x_in);
            if (col_in) cph <= (cph == DXM1) ? 4'd0 : cph + 4'd1;
            if (keep)   ox  <= ox + 10'd1;
          end
        end
        if (href_fall) begin
          if (x_in != H_ACT) err_status[0] <= 1'b1;
          byte_ph <= 1'b0;
          x_in    <= '0;
          cph     <= '0;
          ox      <= '0;
          y_in    <= sat_inc9(y_in);
          if (y_win)    lph <= (lph == DYM1) ? 4'd0 : lph + 4'd1;
          if (row_keep) oy  <= oy + 9'd1;
        end
        if (vs_rise) begin
          if (y_in == V_ACT) frame_done    <= 1'b1;
          else               err_status[1] <= 1'b1;
        end
      end
    end
  end

  // ---- stage p1: single output register with drop-on-full accounting
  always_ff @(posedge c_PCLK) begin
    if (rst) begin
      pix_valid    <= 1'b0;
      pix_data     <= '0;
      pix_x        <= '0;
      pix_y        <= '0;
      pix_sof      <= 1'b0;
      pix_eol      <= 1'b0;
      overflow_cnt <= '0;
    end else if (keep && (!pix_valid || pix_ready)) begin
      pix_valid <= 1'b1;
      pix_data  <= pix_word;
      pix_x     <= ox;
      pix_y     <= oy;
      pix_sof   <= (ox == 10'd0) && (oy == 9'd0);
      pix_eol   <= (ox == OWM1);
    end else begin
      if (keep)      overflow_cnt <= sat_inc16(overflow_cnt);
      if (pix_ready) pix_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ov7670_pixel_stream.sv
// Directed bench for ov7670_pixel_stream on a reduced 16x8 sensor with a
// cropped (3,2) 8x5 window decimated by 2 in both directions (4x3 output).
module tb_ov7670_pixel_stream;

  logic        clk = 1'b0;
  logic        rst, capture_en, vsync, href, pix_ready;
  logic [7:0]  dout;
  logic [15:0] pix_data, overflow_cnt;
  logic        pix_valid, pix_sof, pix_eol, frame_done;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [1:0]  err_status;

  ov7670_pixel_stream #(
    .H_ACTIVE(16), .V_ACTIVE(8), .BPP(2),
    .CROP_X0(3), .CROP_Y0(2), .CROP_W(8), .CROP_H(5),
    .DEC_X(2), .DEC_Y(2)
  ) dut (
    .c_PCLK(clk), .rst(rst), .capture_en(capture_en),
    .c_VSYNC(vsync), .c_HREF(href), .c_DOUT(dout),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .frame_done(frame_done), .overflow_cnt(overflow_cnt), .err_status(err_status)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        sof;
    logic        eol;
  } beat_t;

  typedef struct {
    int          idx;
    logic [15:0] d;
    int          x;
    int          y;
    logic        sof;
    logic        eol;
  } vec_t;

  beat_t beats[$];
  int    fd_cnt = 0;
  int    hold_glitch = 0;
  int    n_checks = 0;
  int    n_err = 0;
  int    en_row = -1, ready_low_row = -1, rst_row = -1, short_row = -1;

  logic  prev_hold = 1'b0;
  beat_t prev_beat;

  // Monitor on the falling edge: record accepted beats, frame_done pulses,
  // and any change of a pending pixel while it is stalled.
  always @(negedge clk) begin
    beat_t cur;
    cur = '{d: pix_data, x: pix_x, y: pix_y, sof: pix_sof, eol: pix_eol};
    if (pix_valid && pix_ready) beats.push_back(cur);
    if (frame_done) fd_cnt++;
    if (prev_hold && pix_valid && cur != prev_beat) hold_glitch++;
    prev_hold = pix_valid && !pix_ready;
    prev_beat = cur;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One camera frame: VSYNC pulse, then nlines HREF lines of 16 pixels
  // (15 on short_row), two bytes each: b0 = {row,col}, b1 = ~b0.
  task automatic send_frame(input int nlines);
    int len;
    logic [7:0] b0;
    vsync = 1'b1; href = 1'b0; dout = 8'h00;
    repeat (3) tick;
    beats.delete();
    fd_cnt = 0;
    vsync = 1'b0;
    repeat (4) tick;
    for (int r = 0; r < nlines; r++) begin
      if (r == en_row) capture_en = 1'b1;
      if (r == ready_low_row) pix_ready = 1'b0;
      len = (r == short_row) ? 15 : 16;
      for (int b = 0; b < 2 * len; b++) begin
        if (r == rst_row && b == 8) begin
          chk("valid_before_rst", 32'(pix_valid), 32'd1);
          rst = 1'b1;
        end
        b0 = {4'(r), 4'(b / 2)};
        href = 1'b1;
        dout = (b % 2 == 0) ? b0 : ~b0;
        tick;
        if (rst) begin
          rst = 1'b0;
          chk("rst_valid", 32'(pix_valid), 32'd0);
          chk("rst_data", 32'(pix_data), 32'd0);
          chk("rst_xy_sof_eol", {pix_x, pix_y, pix_sof, pix_eol}, 32'd0);
          chk("rst_overflow", 32'(overflow_cnt), 32'd0);
          chk("rst_err", 32'(err_status), 32'd0);
        end
      end
      href = 1'b0;
      dout = 8'h00;
      if (r == ready_low_row) pix_ready = 1'b1;
      repeat (4) tick;
    end
    vsync = 1'b1;
    repeat (4) tick;
  endtask

  vec_t vt[6];

  initial begin
    vt[0] = '{idx: 0,  d: 16'h23DC, x: 0, y: 0, sof: 1'b1, eol: 1'b0};
    vt[1] = '{idx: 1,  d: 16'h25DA, x: 1, y: 0, sof: 1'b0, eol: 1'b0};
    vt[2] = '{idx: 3,  d: 16'h29D6, x: 3, y: 0, sof: 1'b0, eol: 1'b1};
    vt[3] = '{idx: 4,  d: 16'h43BC, x: 0, y: 1, sof: 1'b0, eol: 1'b0};
    vt[4] = '{idx: 6,  d: 16'h47B8, x: 2, y: 1, sof: 1'b0, eol: 1'b0};
    vt[5] = '{idx: 11, d: 16'h6996, x: 3, y: 2, sof: 1'b0, eol: 1'b1};

    rst = 1'b1; capture_en = 1'b0; vsync = 1'b0; href = 1'b0;
    dout = 8'h00; pix_ready = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    chk("reset_valid", 32'(pix_valid), 32'd0);
    chk("reset_data", 32'(pix_data), 32'd0);
    chk("reset_overflow", 32'(overflow_cnt), 32'd0);
    chk("reset_err", 32'(err_status), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);

    // Full frame, always ready: table of expected beats
    capture_en = 1'b1;
    tick;
    send_frame(8);
    chk("f1_beats", 32'(beats.size()), 32'd12);
    chk("f1_frame_done", 32'(fd_cnt), 32'd1);
    chk("f1_err", 32'(err_status), 32'd0);
    foreach (vt[i]) begin
      chk("f1_beat_present", 32'(vt[i].idx < beats.size()), 32'd1);
      if (vt[i].idx < beats.size()) begin
        chk($sformatf("f1_data[%0d]", vt[i].idx), 32'(beats[vt[i].idx].d), 32'(vt[i].d));
        chk($sformatf("f1_x[%0d]", vt[i].idx), 32'(beats[vt[i].idx].x), 32'(vt[i].x));
        chk($sformatf("f1_y[%0d]", vt[i].idx), 32'(beats[vt[i].idx].y), 32'(vt[i].y));
        chk($sformatf("f1_sof[%0d]", vt[i].idx), 32'(beats[vt[i].idx].sof), 32'(vt[i].sof));
        chk($sformatf("f1_eol[%0d]", vt[i].idx), 32'(beats[vt[i].idx].eol), 32'(vt[i].eol));
      end
    end

    // Back-pressure through the whole of the first kept line: first pixel
    // held, the other three of that line dropped.
    ready_low_row = 2;
    send_frame(8);
    ready_low_row = -1;
    chk("bp_beats", 32'(beats.size()), 32'd9);
    chk("bp_overflow", 32'(overflow_cnt), 32'd3);
    if (beats.size() >= 2) begin
      chk("bp_held_data", 32'(beats[0].d), 32'h23DC);
      chk("bp_next_data", 32'(beats[1].d), 32'h43BC);
      chk("bp_next_xy", {beats[1].x, beats[1].y}, {10'd0, 9'd1});
    end

    // capture_en raised mid-frame: nothing until the next VSYNC fall
    capture_en = 1'b0;
    repeat (3) tick;
    en_row = 3;
    send_frame(8);
    en_row = -1;
    chk("late_en_beats", 32'(beats.size()), 32'd0);
    chk("late_en_frame_done", 32'(fd_cnt), 32'd0);
    send_frame(8);
    chk("after_en_beats", 32'(beats.size()), 32'd12);

    // Reset mid-line with a stalled pixel pending
    ready_low_row = 2;
    rst_row = 2;
    send_frame(8);
    ready_low_row = -1;
    rst_row = -1;
    chk("post_rst_beats", 32'(beats.size()), 32'd0);
    send_frame(8);
    chk("resume_beats", 32'(beats.size()), 32'd12);
    if (beats.size() > 0) begin
      chk("resume_sof", 32'(beats[0].sof), 32'd1);
      chk("resume_data", 32'(beats[0].d), 32'h23DC);
    end

    // Short line: sticky length error, lines still counted
    short_row = 5;
    send_frame(8);
    short_row = -1;
    chk("short_err", 32'(err_status), 32'd1);
    chk("short_frame_done", 32'(fd_cnt), 32'd1);
    chk("short_beats", 32'(beats.size()), 32'd12);
    if (beats.size() == 12) begin
      chk("short_last_y", 32'(beats[11].y), 32'd2);
      chk("short_last_data", 32'(beats[11].d), 32'h6996);
    end

    // Frame one line short: line-count error, no frame_done
    send_frame(7);
    chk("short_frame_err", 32'(err_status), 32'd3);
    chk("short_frame_done_none", 32'(fd_cnt), 32'd0);

    chk("hold_stable", 32'(hold_glitch), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
